// File: rtl/fifo_burst_writer.sv
// Burst write master: 2-entry in-order buffer feeding a FIFO write port in bursts separated by idle gaps.
// Defining FIFO_BURST_WRITER_STATS_EN adds a saturating stall_cycles counter output.
module fifo_burst_writer #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 8,
  parameter int GAP_CYC   = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             en,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             burst_done,
  output logic [15:0]      words_written
`ifdef FIFO_BURST_WRITER_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, STALL, GAP} state_t;

  localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_t           state_reg, state_next;
  logic [DSIZE-1:0] buf_data_reg [2];
  logic             buf_last_reg [2];
  logic             rd_ptr_reg, wr_ptr_reg;
  logic [1:0]       count_reg, count_next;
  logic [7:0]       beat_cnt_reg, beat_cnt_next;
  logic [7:0]       gap_cnt_reg, gap_cnt_next;
  logic [15:0]      words_written_reg;
  logic             push, pop, head_last, burst_end;

  assign s_ready       = (count_reg != 2'd2);
  assign push          = s_valid & s_ready;
  assign winc          = (state_reg == BURST) && (count_reg != 2'd0) && !wfull;
  assign pop           = winc;
  assign wdata         = buf_data_reg[rd_ptr_reg];
  assign head_last     = buf_last_reg[rd_ptr_reg];
  // A burst closes on its BURST_LEN-th write or on a packet end, whichever comes first.
  assign burst_end     = winc && (head_last || (beat_cnt_reg == BEAT_LAST));
  assign burst_done    = burst_end;
  assign words_written = words_written_reg;

  always_ff @(posedge wclk) begin
    if (push) begin
      buf_data_reg[wr_ptr_reg] <= s_data;
      buf_last_reg[wr_ptr_reg] <= s_last;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (en && (count_reg != 2'd0)) begin
          state_next    = BURST;
          beat_cnt_next = 8'd0;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_next    = (GAP_CYC > 0) ? GAP : IDLE;
          beat_cnt_next = 8'd0;
          gap_cnt_next  = 8'd0;
        end else if (winc) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
        end else if (wfull && (count_reg != 2'd0)) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (!wfull) state_next = BURST;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
        else gap_cnt_next = gap_cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg         <= IDLE;
      count_reg         <= 2'd0;
      rd_ptr_reg        <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      beat_cnt_reg      <= 8'd0;
      gap_cnt_reg       <= 8'd0;
      words_written_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      beat_cnt_reg <= beat_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      if (winc) words_written_reg <= words_written_reg + 16'd1;
    end
  end

`ifdef FIFO_BURST_WRITER_STATS_EN
  logic [15:0] stall_cycles_reg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cycles_reg <= 16'd0;
    end else if ((state_reg == STALL) && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: vector table, directed corner sequences, random traffic
// against a queue-based reference model, and a wrap test on a second instance (BURST_LEN=255, GAP_CYC=0).
module tb_fifo_burst_writer;

  localparam int BL  = 8;
  localparam int GAP = 2;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        en, s_valid, s_last, wfull;
  logic [7:0]  s_data, wdata;
  logic        s_ready, winc, burst_done;
  logic [15:0] words_written;
  logic        en2, s_valid2, s_last2, wfull2;
  logic [7:0]  s_data2, wdata2;
  logic        s_ready2, winc2, done2;
  logic [15:0] ww2;
`ifdef FIFO_BURST_WRITER_STATS_EN
  logic [15:0] stall_cycles, stall_cycles2;
`endif

  always #5 wclk = ~wclk;

  fifo_burst_writer #(.DSIZE(8), .BURST_LEN(BL), .GAP_CYC(GAP)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .burst_done(burst_done), .words_written(words_written)
`ifdef FIFO_BURST_WRITER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fifo_burst_writer #(.DSIZE(8), .BURST_LEN(255), .GAP_CYC(0)) dut2 (
    .wclk(wclk), .wrst_n(wrst_n), .en(en2), .s_valid(s_valid2), .s_data(s_data2),
    .s_last(s_last2), .s_ready(s_ready2), .wfull(wfull2), .winc(winc2), .wdata(wdata2),
    .burst_done(done2), .words_written(ww2)
`ifdef FIFO_BURST_WRITER_STATS_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  int total = 0;
  int bad   = 0;

  // values sampled one step before the rising edge that acts on them
  logic        o_winc, o_ready, o_done;
  logic [7:0]  o_wdata;
  logic [15:0] o_ww;

  // reference model state
  logic [8:0]  mq[$];
  logic [15:0] m_ww;
  int          m_beats, quiet;
  logic        m_in_burst, m_may_start;

  logic [8:0]  src_q[$];
  logic        h_winc[32], h_ready[32], h_done[32];
  logic [7:0]  h_wdata[32];

  typedef struct {
    logic        en, v;
    logic [7:0]  d;
    logic        e_winc, e_ready, e_done;
    logic [7:0]  e_wdata;
    logic [15:0] e_ww;
  } vec_t;
  vec_t tbl[19];

  function automatic vec_t mk(input logic en_i, v_i, input logic [7:0] d_i,
                              input logic ew, er, ed, input logic [7:0] ewd, input logic [15:0] eww);
    vec_t r;
    r.en = en_i; r.v = v_i; r.d = d_i;
    r.e_winc = ew; r.e_ready = er; r.e_done = ed; r.e_wdata = ewd; r.e_ww = eww;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ww = 16'd0; m_beats = 0; quiet = 0; m_in_burst = 1'b0; m_may_start = 1'b0;
  endtask

  // Rules: writes drain accepted words in order, one per winc; a burst ends on its
  // BL-th write or a last word; at least GAP+1 silent cycles follow; occupancy caps at 2.
  task automatic model_step();
    logic [8:0] head;
    logic       exp_done;
    if (quiet > 0) begin
      check("gap_quiet", o_winc, 1'b0);
      quiet--;
    end
    if (wfull) check("winc_while_full", o_winc, 1'b0);
    check("ready_vs_occupancy", o_ready, mq.size() < 2);
    check("words_written", o_ww, m_ww);
    if (o_winc) begin
      check("write_nonempty", mq.size() != 0, 1'b1);
      if (mq.size() != 0) begin
        head = mq.pop_front();
        check("wdata_order", o_wdata, head[7:0]);
        if (!m_in_burst) begin
          check("burst_start_needs_en", m_may_start, 1'b1);
          m_in_burst = 1'b1; m_may_start = 1'b0;
        end
        m_beats++;
        exp_done = head[8] || (m_beats == BL);
        check("burst_done_rule", o_done, exp_done);
        if (exp_done) begin
          m_in_burst = 1'b0; m_beats = 0; quiet = GAP + 1;
        end
      end
      m_ww = m_ww + 16'd1;
    end else begin
      check("done_without_write", o_done, 1'b0);
    end
    if (!m_in_burst && en) m_may_start = 1'b1;
    if (s_valid && o_ready) mq.push_back({s_last, s_data});
  endtask

  task automatic step(input logic en_i, v_i, input logic [7:0] d_i, input logic l_i, wf_i);
    @(negedge wclk);
    en = en_i; s_valid = v_i; s_data = d_i; s_last = l_i; wfull = wf_i;
    #1;
    o_winc = winc; o_ready = s_ready; o_done = burst_done; o_wdata = wdata; o_ww = words_written;
    model_step();
  endtask

  task automatic src_step(input logic en_i, wf_i);
    if (src_q.size() > 0) step(en_i, 1'b1, src_q[0][7:0], src_q[0][8], wf_i);
    else                  step(en_i, 1'b0, 8'h00, 1'b0, wf_i);
    if (s_valid && o_ready) void'(src_q.pop_front());
  endtask

  task automatic run_hist(input int n, input int en_until, input int wf_from, input int wf_to);
    for (int i = 0; i < n; i++) begin
      src_step(i < en_until, (i >= wf_from) && (i <= wf_to));
      h_winc[i] = o_winc; h_ready[i] = o_ready; h_done[i] = o_done; h_wdata[i] = o_wdata;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_winc", winc, 1'b0);
    check("rst_burst_done", burst_done, 1'b0);
    check("rst_words_written", words_written, 16'd0);
`ifdef FIFO_BURST_WRITER_STATS_EN
    check("rst_stall_cycles", stall_cycles, 16'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_last = 1'b0; wfull = 1'b0; s_data = 8'h00;
    #1;
    check_reset_outputs();
    model_reset();
    src_q.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_last = 1'b0; wfull = 1'b0; s_data = 8'h00;
    en2 = 1'b0; s_valid2 = 1'b0; s_last2 = 1'b0; wfull2 = 1'b0; s_data2 = 8'h5A;
    model_reset();
    do_reset();

    // full 8-word burst, 2 gap cycles, idle hold with en low, burst waiting on empty buffer
    tbl[0]  = mk(1, 1, 8'hA0, 0, 1, 0, 8'h00, 16'd0);
    tbl[1]  = mk(1, 1, 8'hA1, 0, 1, 0, 8'h00, 16'd0);
    tbl[2]  = mk(1, 1, 8'hA2, 1, 0, 0, 8'hA0, 16'd0);
    tbl[3]  = mk(1, 1, 8'hA2, 1, 1, 0, 8'hA1, 16'd1);
    tbl[4]  = mk(1, 1, 8'hA3, 1, 1, 0, 8'hA2, 16'd2);
    tbl[5]  = mk(1, 1, 8'hA4, 1, 1, 0, 8'hA3, 16'd3);
    tbl[6]  = mk(1, 1, 8'hA5, 1, 1, 0, 8'hA4, 16'd4);
    tbl[7]  = mk(1, 1, 8'hA6, 1, 1, 0, 8'hA5, 16'd5);
    tbl[8]  = mk(1, 1, 8'hA7, 1, 1, 0, 8'hA6, 16'd6);
    tbl[9]  = mk(1, 0, 8'h00, 1, 1, 1, 8'hA7, 16'd7);
    tbl[10] = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 16'd8);
    tbl[11] = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 16'd8);
    tbl[12] = mk(0, 1, 8'hA8, 0, 1, 0, 8'h00, 16'd8);
    tbl[13] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 16'd8);
    tbl[14] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 16'd8);
    tbl[15] = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 16'd8);
    tbl[16] = mk(1, 0, 8'h00, 1, 1, 0, 8'hA8, 16'd8);
    tbl[17] = mk(0, 1, 8'hA9, 0, 1, 0, 8'h00, 16'd9);
    tbl[18] = mk(0, 0, 8'h00, 1, 1, 0, 8'hA9, 16'd9);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].d, 1'b0, 1'b0);
      check($sformatf("tbl%0d_winc", i), o_winc, tbl[i].e_winc);
      check($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_done", i), o_done, tbl[i].e_done);
      check($sformatf("tbl%0d_ww", i), o_ww, tbl[i].e_ww);
      if (tbl[i].e_winc) check($sformatf("tbl%0d_wdata", i), o_wdata, tbl[i].e_wdata);
    end

    // wfull held for 5 cycles after the 3rd write
    begin
      int nw;
      do_reset();
      for (int i = 0; i < 8; i++) src_q.push_back({1'b0, 8'hB0 + 8'(i)});
      run_hist(24, 99, 5, 9);
      for (int i = 5; i <= 9; i++) check($sformatf("stall_winc_s%0d", i), h_winc[i], 1'b0);
      check("stall_ready_full", h_ready[6], 1'b0);
      nw = 0;
      for (int i = 0; i < 24; i++) begin
        if (h_winc[i]) begin
          if (nw < 8) check($sformatf("stall_order%0d", nw), h_wdata[i], 8'hB0 + 8'(nw));
          nw++;
        end
      end
      check("stall_write_count", nw, 8);
      check("stall_done_last", h_done[15], 1'b1);
      check("stall_last_data", h_wdata[15], 8'hB7);
`ifdef FIFO_BURST_WRITER_STATS_EN
      check("stall_cycles", stall_cycles, 16'd5);
`endif
    end

    // s_last on the 3rd word closes the burst early
    do_reset();
    src_q.push_back({1'b0, 8'hD0}); src_q.push_back({1'b0, 8'hD1}); src_q.push_back({1'b1, 8'hD2});
    src_q.push_back({1'b0, 8'hD3}); src_q.push_back({1'b0, 8'hD4});
    run_hist(16, 99, 100, 0);
    check("last_done", h_done[4], 1'b1);
    check("last_done_data", h_wdata[4], 8'hD2);
    for (int i = 5; i <= 7; i++) check($sformatf("last_gap_s%0d", i), h_winc[i], 1'b0);
    check("last_resume_winc", h_winc[8], 1'b1);
    check("last_resume_data", h_wdata[8], 8'hD3);
    check("last_resume_nodone", h_done[8], 1'b0);
    check("last_next_data", h_wdata[9], 8'hD4);

    // reset while BURST holds 2 words
    do_reset();
    src_q.push_back({1'b1, 8'hC0}); src_q.push_back({1'b0, 8'hC1}); src_q.push_back({1'b0, 8'hC2});
    run_hist(7, 99, 100, 0);
    check("rmid_first_done", h_done[2], 1'b1);
    check("rmid_first_data", h_wdata[2], 8'hC0);
    check("rmid_pre_winc", h_winc[6], 1'b1);
    check("rmid_pre_data", h_wdata[6], 8'hC1);
    check("rmid_pre_full", h_ready[6], 1'b0);
    #1 wrst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    src_q.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_step(1'b1, 1'b0);
      check($sformatf("rmid_nowrite%0d", i), o_winc, 1'b0);
      check($sformatf("rmid_nodone%0d", i), o_done, 1'b0);
    end

    // en dropped after the 2nd write of a 4-word packet
    do_reset();
    for (int i = 0; i < 6; i++) src_q.push_back({(i == 3), 8'hE0 + 8'(i)});
    run_hist(16, 4, 100, 0);
    check("endrop_w1", h_wdata[2], 8'hE0);
    check("endrop_w2", h_wdata[3], 8'hE1);
    check("endrop_w3_winc", h_winc[4], 1'b1);
    check("endrop_w3", h_wdata[4], 8'hE2);
    check("endrop_w4_winc", h_winc[5], 1'b1);
    check("endrop_w4", h_wdata[5], 8'hE3);
    check("endrop_done", h_done[5], 1'b1);
    for (int i = 6; i < 16; i++) check($sformatf("endrop_idle%0d", i), h_winc[i], 1'b0);
    check("endrop_buffer_full", h_ready[15], 1'b0);

    // random traffic against the reference model, with one reset mid-run
    begin
      logic       pend;
      logic [8:0] pw;
      do_reset();
      pend = 1'b0; pw = 9'h000;
      for (int i = 0; i < 2400; i++) begin
        if (i == 1200) begin
          do_reset();
          pend = 1'b0;
        end
        if (!pend && ($urandom_range(9) < 6)) begin
          pw = {($urandom_range(4) == 0), 8'($urandom)};
          pend = 1'b1;
        end
        step($urandom_range(9) < 8, pend, pw[7:0], pw[8], $urandom_range(3) == 0);
        if (pend && o_ready) pend = 1'b0;
      end
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_empty", mq.size(), 0);
    end

    // words_written wrap and BURST_LEN=255 / GAP_CYC=0 timing on the second instance
    begin
      int n2, cyc, gap_chk;
      n2 = 0; cyc = 0; gap_chk = 0;
      en2 = 1'b1; s_valid2 = 1'b1;
      while (n2 < 65537 && cyc < 70000) begin
        @(negedge wclk);
        #1;
        cyc++;
        if (gap_chk == 2) begin
          check("gap0_idle", winc2, 1'b0);
          gap_chk = 1;
        end else if (gap_chk == 1) begin
          check("gap0_resume", winc2, 1'b1);
          gap_chk = 0;
        end
        if (n2 == 255 || n2 == 65535 || n2 == 65536) check($sformatf("wrap_ww_at%0d", n2), ww2, n2 & 32'hFFFF);
        if (winc2) begin
          if (n2 < 1024) begin
            check("len255_done", done2, (n2 % 255) == 254);
            if (done2) gap_chk = 2;
          end
          n2++;
        end
      end
      en2 = 1'b0; s_valid2 = 1'b0;
      check("wrap_reached", n2 >= 65537, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data word width.
REQ-002 SHALL have parameter BURST_LEN, default 8: maximum words per burst, 1..255.
REQ-003 SHALL have parameter GAP_CYC, default 2: idle cycles between bursts, 0..255.
REQ-004 SHALL have port wclk, input, 1: write-domain clock; all state updates on rising edge.
REQ-005 SHALL have port wrst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1: when high, new bursts are permitted to start.
REQ-007 SHALL have port s_valid, input, 1: upstream word valid.
REQ-008 SHALL have port s_data, input, DSIZE: upstream word.
REQ-009 SHALL have port s_last, input, 1: upstream word ends a packet.
REQ-010 SHALL have port s_ready, output, 1: buffer can accept a word.
REQ-011 SHALL have port wfull, input, 1: FIFO full flag from the write-pointer/full block.
REQ-012 SHALL have port winc, output, 1: FIFO write strobe.
REQ-013 SHALL have port wdata, output, DSIZE: FIFO write data.
REQ-014 SHALL have port burst_done, output, 1: one-cycle pulse at burst completion.
REQ-015 SHALL have port words_written, output, 16: count of FIFO writes.

Function
REQ-016 SHALL hold a 2-entry in-order buffer of {data, last}, with occupancy count 0..2; accept = s_valid & s_ready; s_ready = (count != 2).
REQ-017 SHALL drive wdata from the buffer head at all times; wdata is don't-care when count == 0.
REQ-018 SHALL drive winc = (state == BURST) & (count != 0) & ~wfull, combinationally; a write occurs on every edge where winc == 1.
REQ-019 SHALL, on a simultaneous accept and write, pop the head and push the new word in the same cycle, leaving count unchanged.
REQ-020 SHALL implement FSM states IDLE, BURST, STALL and GAP.
REQ-021 SHALL transition IDLE->BURST when en & (count != 0); the burst counter is cleared on entry.
REQ-022 SHALL transition BURST->STALL when wfull & (count != 0), and STALL->BURST on the first cycle wfull == 0.
REQ-023 SHALL end a burst on the write of the BURST_LEN-th word, or of a word with last == 1, whichever comes first; burst_done pulses high in that same cycle.
REQ-024 SHALL, at burst end, go to GAP if GAP_CYC > 0, otherwise to IDLE; GAP lasts exactly GAP_CYC cycles and then goes to IDLE.
REQ-025 SHALL remain in BURST while count == 0 and the burst is unfinished; the burst resumes when data arrives.
REQ-026 SHALL let a burst in progress run to completion when en is deasserted mid-burst.
REQ-027 SHALL increment words_written by 1 per write, wrapping from 0xFFFF to 0.
REQ-028 SHALL keep s_ready independent of wfull and FSM state.

Reset
REQ-029 SHALL, on wrst_n low, asynchronously force state = IDLE, count = 0, burst counter = 0, GAP counter = 0, words_written = 0 and burst_done = 0; s_ready = 1 and winc = 0 follow from those values.
REQ-030 SHALL discard buffered words and any partial burst on reset mid-operation, without a burst_done pulse.
REQ-031 SHALL produce its first possible winc no earlier than the second rising edge after wrst_n deasserts.

Configuration
REQ-032 SHALL, with macro FIFO_BURST_WRITER_STATS_EN defined, add output stall_cycles[15:0]: increments each cycle in STALL, saturates at 0xFFFF, and is reset to 0.
REQ-033 SHALL, without FIFO_BURST_WRITER_STATS_EN, omit the stall_cycles port and its logic; all other behaviour is identical.

Verification
REQ-034 Bench SHALL cover: en = 1, wfull = 0, 8 consecutive words with s_last = 0 and BURST_LEN = 8 -> 8 consecutive winc pulses, burst_done on the 8th write, then 2 GAP cycles with winc = 0, and words_written = 8.
REQ-035 Bench SHALL cover: wfull = 1 for 5 cycles after the 3rd write -> winc = 0 for those cycles, s_ready = 0 once 2 words are buffered, and the remaining 5 words written in order afterward (stall_cycles = 5 when STATS_EN is defined).
REQ-036 Bench SHALL cover: s_last = 1 on the 3rd word -> burst_done with the 3rd write, and the 4th word written only after GAP.
REQ-037 Bench SHALL cover: wrst_n pulsed low with count == 2 during BURST -> state IDLE, no winc and no burst_done, and the buffered words never written.
REQ-038 Bench SHALL cover: words_written preloaded to 0xFFFF by 65535 writes, then 1 more write -> words_written = 0x0000.
REQ-039 Bench SHALL cover: en dropped after the 2nd write of a 4-word packet -> words 3 and 4 still written with burst_done, and no new burst starts.
